// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with tag/valid/dirty arrays.
// Data lines live in an external cache_data_memory; misses are served over a req/ack word bus.
module cache_controller #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              data_we,
    output logic [IDX_W-1:0]  idx,
    output logic [DATA_W-1:0] data_block_in,
    input  logic [DATA_W-1:0] data_block_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFFSET_W;
    localparam int unsigned LINE_W = ADDR_W - OFFSET_W;
    localparam int unsigned LINES  = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   req_line_q;
    logic                req_we_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic [LINES-1:0]    valid_q;
    logic [LINES-1:0]    dirty_q;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic                alloc_gap_q;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [TAG_W-1:0]    cur_tag;
    logic                hit;
    logic                set_dirty;
    logic                refill;
    logic                offset_unused;

    // Byte-offset bits never select anything: one line holds exactly one word.
    assign offset_unused = ^cpu_addr[OFFSET_W-1:0];

    assign req_tag = req_line_q[LINE_W-1 -: TAG_W];
    assign req_idx = req_line_q[IDX_W-1:0];
    assign cur_tag = tag_q[req_idx];
    assign hit     = valid_q[req_idx] && (cur_tag == req_tag);
    assign idx     = req_idx;

    // State, latched request and per-line status bits.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= IDLE;
            req_line_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            alloc_gap_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            alloc_gap_q <= (state_q == WRITEBACK) && mem_ack;
            if ((state_q == IDLE) && cpu_req) begin
                req_line_q  <= cpu_addr[ADDR_W-1:OFFSET_W];
                req_we_q    <= cpu_we;
                req_wdata_q <= cpu_wdata;
            end
            if (set_dirty) begin
                dirty_q[req_idx] <= 1'b1;
            end
            if (refill) begin
                valid_q[req_idx] <= 1'b1;
                dirty_q[req_idx] <= 1'b0;
            end
        end
    end

    // Tags are only meaningful behind a set valid bit, so they need no reset.
    always_ff @(posedge iCLK) begin
        if (refill) begin
            tag_q[req_idx] <= req_tag;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d       = state_q;
        cpu_rdata     = '0;
        cpu_ready     = 1'b0;
        data_we       = 1'b0;
        data_block_in = '0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        set_dirty     = 1'b0;
        refill        = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                    if (req_we_q) begin
                        data_we       = 1'b1;
                        data_block_in = req_wdata_q;
                        set_dirty     = 1'b1;
                    end else begin
                        cpu_rdata = data_block_out;
                    end
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cur_tag, req_idx, OFFSET_W'(0)};
                mem_wdata = data_block_out;
                if (mem_ack) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                // One idle cycle after a writeback ack separates the two memory requests.
                if (!alloc_gap_q) begin
                    mem_req  = 1'b1;
                    mem_addr = {req_tag, req_idx, OFFSET_W'(0)};
                    if (mem_ack) begin
                        data_we       = 1'b1;
                        data_block_in = mem_rdata;
                        refill        = 1'b1;
                        state_d       = COMPARE;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: flat-memory reference model with a tag directory,
// a randomized-latency main memory and a behavioural cache_data_memory.
module tb_cache_controller;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic        cpu_req, cpu_we, cpu_ready;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        data_we;
    logic [4:0]  idx;
    logic [31:0] data_block_in, data_block_out;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    cache_controller dut (
        .iCLK(iCLK), .iRST_n(iRST_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .data_we(data_we), .idx(idx), .data_block_in(data_block_in), .data_block_out(data_block_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial forever #5 iCLK = ~iCLK;

    // cache_data_memory: combinational read, synchronous write
    logic [31:0] dmem [32];
    always @(posedge iCLK) if (data_we) dmem[idx] <= data_block_in;
    assign data_block_out = dmem[idx];

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int dly; } mem_op_t;
    typedef struct { logic we; logic [31:0] rdata; int lat; int cyc; } cpu_exp_t;

    mem_op_t  exp_mem [$];
    cpu_exp_t exp_cpu [$];

    // Reference: flat memory view (shadow) over main memory (backing), plus a tag directory
    logic [31:0] backing [logic [31:0]];
    logic [31:0] shadow  [logic [31:0]];
    logic        m_valid [32];
    logic        m_dirty [32];
    logic [31:0] m_tag   [32];

    function automatic logic [31:0] backing_rd(input logic [31:0] a);
        if (backing.exists(a)) return backing[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        if (shadow.exists(a)) return shadow[a];
        return backing_rd(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        shadow.delete();
        exp_mem.delete();
        exp_cpu.delete();
    endtask

    task automatic model_access(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                                input int wb_dly, input int rf_dly);
        logic [31:0] la, t;
        int          i, wbd, rfd;
        cpu_exp_t    e;
        mem_op_t     op;
        la  = addr & 32'hFFFF_FFFC;
        i   = int'(addr[6:2]);
        t   = addr >> 7;
        wbd = (wb_dly < 0) ? int'($urandom_range(0, 3)) : wb_dly;
        rfd = (rf_dly < 0) ? int'($urandom_range(0, 3)) : rf_dly;
        e.we    = we;
        e.rdata = '0;
        e.cyc   = cyc;
        if (m_valid[i] && m_tag[i] == t) begin
            e.lat = 1;
        end else begin
            if (m_valid[i] && m_dirty[i]) begin
                op.we    = 1'b1;
                op.addr  = (m_tag[i] << 7) | (32'(i) << 2);
                op.wdata = shadow_rd(op.addr);
                op.dly   = wbd;
                exp_mem.push_back(op);
                e.lat = 3 + (wbd + 1) + (rfd + 1);
            end else begin
                e.lat = 2 + (rfd + 1);
            end
            op.we    = 1'b0;
            op.addr  = la;
            op.wdata = '0;
            op.dly   = rfd;
            exp_mem.push_back(op);
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_dirty[i] = 1'b0;
        end
        if (we) begin
            shadow[la] = wd;
            m_dirty[i] = 1'b1;
        end else begin
            e.rdata = shadow_rd(la);
        end
        exp_cpu.push_back(e);
    endtask

    // CPU-side monitor
    initial begin
        cpu_exp_t e;
        forever begin
            @(negedge iCLK); #1;
            if (iRST_n && cpu_ready) begin
                if (exp_cpu.size() == 0) begin
                    chk("cpu_ready_unexpected", 32'(cpu_ready), 32'd0);
                end else begin
                    e = exp_cpu.pop_front();
                    if (!e.we) chk("load_rdata", cpu_rdata, e.rdata);
                    chk("latency", 32'(cyc - e.cyc), 32'(e.lat));
                end
            end
        end
    end

    // Main memory responder and memory-side monitor
    mem_op_t cur;
    logic    pending = 1'b0;
    logic    wb_gap  = 1'b0;
    int      cnt     = 0;
    int      mreq_cnt = 0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge iCLK); #1;
            mem_ack = 1'b0;
            if (mem_req) mreq_cnt++;
            if (!iRST_n) begin
                pending = 1'b0;
                wb_gap  = 1'b0;
            end else begin
                if (wb_gap) chk("mem_req_gap_after_wb", 32'(mem_req), 32'd0);
                wb_gap = 1'b0;
                if (mem_req) begin
                    if (!pending) begin
                        pending = 1'b1;
                        if (exp_mem.size() == 0) begin
                            chk("mem_req_unexpected", 32'(mem_req), 32'd0);
                            cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata; cur.dly = 0;
                        end else begin
                            cur = exp_mem.pop_front();
                        end
                        cnt = cur.dly;
                    end
                    if (cnt == 0) begin
                        chk("mem_we", 32'(mem_we), 32'(cur.we));
                        chk("mem_addr", mem_addr, cur.addr);
                        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                        mem_rdata = mem_we ? $urandom : backing_rd(mem_addr);
                        if (mem_we) backing[mem_addr] = mem_wdata;
                        mem_ack = 1'b1;
                        pending = 1'b0;
                        wb_gap  = mem_we;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cpu_ready && n < 400) begin
            @(negedge iCLK);
            n++;
        end
        chk("ready_seen", 32'(cpu_ready), 32'd1);
    endtask

    task automatic do_req(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                          input int wb_dly, input int rf_dly);
        model_access(addr, we, wd, wb_dly, rf_dly);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(negedge iCLK);
        cpu_req = 1'b0;
        wait_ready();
        @(negedge iCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          m0, n;
        logic [31:0] a0, w0;
        iRST_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        model_reset();
        backing[32'h10] = 32'hDEADBEEF;
        repeat (2) @(negedge iCLK);
        #2;
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_data_we", 32'(data_we), 32'd0);
        chk("rst_idx", 32'(idx), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(negedge iCLK); iRST_n = 1'b1;
        @(negedge iCLK);

        // cold load miss with 3-cycle memory wait
        do_req(32'h10, 1'b0, '0, 0, 3);
        // hit: no memory traffic
        m0 = mreq_cnt;
        do_req(32'h10, 1'b0, '0, 0, 0);
        chk("hit_no_mem_req", 32'(mreq_cnt - m0), 32'd0);
        // store hit then conflicting load: writeback then refill
        do_req(32'h10, 1'b1, 32'h12345678, 0, 0);
        do_req(32'h90, 1'b0, '0, 1, 2);
        // store miss on an invalid line, then read it back
        do_req(32'h204, 1'b1, 32'hCAFEF00D, 0, 1);
        do_req(32'h204, 1'b0, '0, 0, 0);

        // reset while a refill is outstanding
        model_access(32'h10, 1'b0, '0, 0, 10);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        @(negedge iCLK);
        cpu_req = 1'b0;
        n = 0;
        while (!(mem_req && !mem_we) && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        chk("alloc_req_seen", 32'(mem_req), 32'd1);
        iRST_n = 1'b0;
        #1;
        chk("rst_drops_mem_req", 32'(mem_req), 32'd0);
        chk("rst_cpu_ready_low", 32'(cpu_ready), 32'd0);
        model_reset();
        repeat (2) @(negedge iCLK);
        iRST_n = 1'b1;
        @(negedge iCLK);
        m0 = mreq_cnt;
        do_req(32'h10, 1'b0, '0, 0, 1);
        chk("post_rst_miss_req_cycles", 32'(mreq_cnt - m0), 32'd2);

        // long writeback stall with ignored cpu_req
        do_req(32'h10, 1'b1, 32'hA5A50001, 0, 0);
        model_access(32'h90, 1'b0, '0, 20, 1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h90;
        @(negedge iCLK);
        cpu_req = 1'b0;
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        a0 = mem_addr;
        w0 = mem_wdata;
        for (int k = 0; k < 20; k++) begin
            #2;
            chk("stall_mem_req", 32'(mem_req), 32'd1);
            chk("stall_mem_addr", mem_addr, a0);
            chk("stall_mem_wdata", mem_wdata, w0);
            chk("stall_cpu_ready", 32'(cpu_ready), 32'd0);
            cpu_req = 1'b1; cpu_we = $urandom_range(0, 1) == 1; cpu_addr = $urandom; cpu_wdata = $urandom;
            @(negedge iCLK);
        end
        cpu_req = 1'b0;
        wait_ready();
        @(negedge iCLK);

        // randomized traffic over a few tags and indices
        for (int r = 0; r < 300; r++) begin
            logic [31:0] addr;
            addr = (32'($urandom_range(0, 2)) << 7) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            do_req(addr, $urandom_range(0, 1) == 1, $urandom, -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge iCLK);
        end

        repeat (3) @(negedge iCLK);
        chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
        chk("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
